// File: rtl/bw_io_ssi_resp.sv
// SSI target-side responder.
// Oversamples the initiator's serial clock on the core clock, decodes
// read/write request frames, performs one store access over a req/ack
// handshake and serialises the ack bit plus read data back on ssi_miso.
module bw_io_ssi_resp #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ssi_sck,
    input  logic              ssi_mosi,
    output logic              ssi_miso,
    output logic              ssi_miso_oe,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // The bit counter serves the address field, the write-data field and
    // the read-data response, so it must hold the larger field length.
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_DATA_LEN  = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR    = 3'd2,
        S_WDATA   = 3'd3,
        S_MEMWAIT = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t state_r;
    state_t state_next;

    logic sck_meta_r;
    logic sck_s;
    logic sck_d;
    logic mosi_meta_r;
    logic mosi_s;

    logic rise;
    logic fall;

    logic              rw_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              ack_pend_r;
    logic              ack_sent_r;

    // Edge strobes of the synchronised serial clock; one core cycle wide.
    assign rise = sck_s & ~sck_d;
    assign fall = ~sck_s & sck_d;

    // Two-flop synchronisers with matched latency so mosi lines up with sck.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta_r  <= 1'b0;
            sck_s       <= 1'b0;
            sck_d       <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_s      <= 1'b0;
        end else begin
            sck_meta_r  <= ssi_sck;
            sck_s       <= sck_meta_r;
            sck_d       <= sck_s;
            mosi_meta_r <= ssi_mosi;
            mosi_s      <= mosi_meta_r;
        end
    end

    // Next-state decode: frame fields advance on rises, response on falls.
    always_comb begin
        state_next = state_r;
        case (state_r)
            S_IDLE: begin
                if (rise && mosi_s) begin
                    state_next = S_CMD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CMD: begin
                if (rise) begin
                    state_next = S_ADDR;
                end else begin
                    state_next = S_CMD;
                end
            end
            S_ADDR: begin
                if (rise && (cnt_r == CNT_ZERO)) begin
                    state_next = rw_r ? S_WDATA : S_MEMWAIT;
                end else begin
                    state_next = S_ADDR;
                end
            end
            S_WDATA: begin
                if (rise && (cnt_r == CNT_ZERO)) begin
                    state_next = S_MEMWAIT;
                end else begin
                    state_next = S_WDATA;
                end
            end
            S_MEMWAIT: begin
                if (fall) begin
                    state_next = S_RESP;
                end else begin
                    state_next = S_MEMWAIT;
                end
            end
            S_RESP: begin
                if (fall && ack_sent_r && (cnt_r == CNT_ZERO)) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_RESP;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register and the registered busy flag that follows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_next;
            busy    <= (state_next != S_IDLE);
        end
    end

    // Frame decode, store handshake and response serialiser datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_r        <= 1'b0;
            cnt_r       <= CNT_ZERO;
            shift_r     <= {DATA_W{1'b0}};
            ack_pend_r  <= 1'b0;
            ack_sent_r  <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            ssi_miso    <= 1'b0;
            ssi_miso_oe <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ack_pend_r <= 1'b0;
                    ack_sent_r <= 1'b0;
                end
                S_CMD: begin
                    if (rise) begin
                        rw_r  <= mosi_s;
                        cnt_r <= CNT_ADDR_LAST;
                    end
                end
                S_ADDR: begin
                    if (rise) begin
                        mem_addr <= {mem_addr[ADDR_W-2:0], mosi_s};
                        if (cnt_r == CNT_ZERO) begin
                            if (rw_r) begin
                                cnt_r <= CNT_DATA_LAST;
                            end else begin
                                mem_req <= 1'b1;
                                mem_we  <= 1'b0;
                            end
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
                S_WDATA: begin
                    if (rise) begin
                        mem_wdata <= {mem_wdata[DATA_W-2:0], mosi_s};
                        if (cnt_r == CNT_ZERO) begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
                S_MEMWAIT: begin
                    // First fall after the request frame opens the response.
                    if (fall) begin
                        ssi_miso_oe <= 1'b1;
                        ssi_miso    <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (fall) begin
                        if (!ack_pend_r) begin
                            ssi_miso <= 1'b0;
                        end else if (!ack_sent_r) begin
                            ssi_miso   <= 1'b1;
                            ack_sent_r <= 1'b1;
                            cnt_r      <= rw_r ? CNT_ZERO : CNT_DATA_LEN;
                        end else if (cnt_r != CNT_ZERO) begin
                            ssi_miso <= shift_r[DATA_W-1];
                            shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
                            cnt_r    <= cnt_r - CNT_ONE;
                        end else begin
                            ssi_miso    <= 1'b0;
                            ssi_miso_oe <= 1'b0;
                        end
                    end
                end
                default: begin
                    ssi_miso    <= 1'b0;
                    ssi_miso_oe <= 1'b0;
                end
            endcase

            // The handshake runs independently of the serialiser so that the
            // initiator keeps seeing wait bits until the store answers. An
            // ack that coincides with a fall only becomes visible next fall.
            if (mem_req && mem_ack) begin
                mem_req    <= 1'b0;
                mem_we     <= 1'b0;
                shift_r    <= mem_rdata;
                ack_pend_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bw_io_ssi_resp.sv
// Directed bench for bw_io_ssi_resp: table of request frames with
// hand-computed response streams, plus reset, slow-store, coincident-ack
// and idle-noise sequences.
module tb_bw_io_ssi_resp;

    logic        clk;
    logic        rst;
    logic        ssi_sck;
    logic        ssi_mosi;
    logic        ssi_miso;
    logic        ssi_miso_oe;
    logic        mem_req;
    logic        mem_we;
    logic [27:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic        mem_auto;
    logic        auto_ack;
    logic        man_ack;
    logic [7:0]  auto_rdata;
    logic [7:0]  man_rdata;

    logic        cap_we;
    logic [27:0] cap_addr;
    logic [7:0]  cap_wdata;
    int          cap_cnt;
    logic        req_prev;

    logic [63:0] miso_v;
    logic [63:0] oe_v;
    logic [63:0] req_v;

    int checks;
    int failures;

    typedef struct {
        logic        rw;
        logic [27:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic [15:0] exp_bits;
        int          len;
    } vec_t;

    vec_t vecs [5];

    assign mem_ack   = auto_ack | man_ack;
    assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

    bw_io_ssi_resp #(.ADDR_W(28), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ssi_sck     (ssi_sck),
        .ssi_mosi    (ssi_mosi),
        .ssi_miso    (ssi_miso),
        .ssi_miso_oe (ssi_miso_oe),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Store model: acks three cycles after a request is seen.
    initial begin
        auto_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto && mem_req && !auto_ack) begin
                tick(3);
                auto_ack = 1'b1;
                tick(1);
                auto_ack = 1'b0;
            end
        end
    end

    // Records the request fields at the cycle mem_req rises.
    initial begin
        req_prev = 1'b0;
        cap_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !req_prev) begin
                cap_we    = mem_we;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_cnt++;
            end
            req_prev = mem_req;
        end
    end

    // One serial bit: 8 clk low with data set, 8 clk high, then fall.
    task automatic send_bit(input logic b);
        ssi_mosi = b;
        tick(8);
        ssi_sck = 1'b1;
        tick(8);
        ssi_sck = 1'b0;
    endtask

    task automatic send_frame(input logic rw, input logic [27:0] addr, input logic [7:0] wd);
        send_bit(1'b1);
        send_bit(rw);
        for (int i = 27; i >= 0; i--) send_bit(addr[i]);
        if (rw) begin
            for (int i = 7; i >= 0; i--) send_bit(wd[i]);
        end
        ssi_mosi = 1'b0;
    endtask

    // Clocks n response periods, sampling before each rise.
    // ack_mode 1: manual ack in the high phase of period ack_call.
    // ack_mode 2: manual ack in the same core cycle as the fall that
    //             opens period ack_call.
    task automatic resp_run(input int n, input int ack_call, input int ack_mode, input logic [7:0] rd);
        for (int k = 0; k < n; k++) begin
            if (ack_mode == 2 && k == ack_call) begin
                tick(2);
                man_rdata = rd;
                man_ack   = 1'b1;
                tick(1);
                man_ack   = 1'b0;
                tick(5);
            end else begin
                tick(8);
            end
            miso_v[k] = ssi_miso;
            oe_v[k]   = ssi_miso_oe;
            req_v[k]  = mem_req;
            ssi_sck   = 1'b1;
            if (ack_mode == 1 && k == ack_call) begin
                tick(3);
                man_rdata = rd;
                man_ack   = 1'b1;
                tick(1);
                man_ack   = 1'b0;
                tick(4);
            end else begin
                tick(8);
            end
            ssi_sck = 1'b0;
        end
    endtask

    task automatic run_vector(input int i);
        logic [15:0] act_bits;
        logic [15:0] act_oe;
        logic [15:0] exp_oe;
        int          cnt0;
        vec_t        v;
        v          = vecs[i];
        mem_auto   = 1'b1;
        auto_rdata = v.rdata;
        cnt0       = cap_cnt;
        send_frame(v.rw, v.addr, v.wdata);
        resp_run(v.len + 1, -1, 0, 8'h00);
        act_bits = 16'h0000;
        act_oe   = 16'h0000;
        for (int k = 0; k < v.len; k++) begin
            act_bits[15-k] = miso_v[k];
            act_oe[15-k]   = oe_v[k];
        end
        exp_oe = ~(16'hFFFF >> v.len);
        check($sformatf("v%0d_req_count", i), 64'(cap_cnt - cnt0), 64'd1);
        check($sformatf("v%0d_mem_we", i), 64'(cap_we), 64'(v.rw));
        check($sformatf("v%0d_mem_addr", i), 64'(cap_addr), 64'(v.addr));
        if (v.rw) check($sformatf("v%0d_mem_wdata", i), 64'(cap_wdata), 64'(v.wdata));
        check($sformatf("v%0d_miso_stream", i), 64'(act_bits), 64'(v.exp_bits));
        check($sformatf("v%0d_oe_window", i), 64'(act_oe), 64'(exp_oe));
        check($sformatf("v%0d_end_oe_miso", i), {62'd0, oe_v[v.len], miso_v[v.len]}, 64'd0);
        check($sformatf("v%0d_end_busy_req", i), {62'd0, busy, mem_req}, 64'd0);
    endtask

    initial begin
        int noise_bad;
        int zeros;
        int req_hi;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        ssi_sck    = 1'b0;
        ssi_mosi   = 1'b0;
        mem_auto   = 1'b1;
        man_ack    = 1'b0;
        man_rdata  = 8'h00;
        auto_rdata = 8'h00;
        miso_v     = 64'd0;
        oe_v       = 64'd0;
        req_v      = 64'd0;

        // Expected response streams, MSB-first: entry 0, ack 1, read data.
        vecs[0] = '{1'b0, 28'h0ABCDEF, 8'h00, 8'hA5, {10'b0_1_10100101, 6'd0}, 10};
        vecs[1] = '{1'b1, 28'h0000010, 8'h3C, 8'hEE, {2'b0_1, 14'd0}, 2};
        vecs[2] = '{1'b0, 28'hFFFFFFF, 8'h00, 8'h00, {10'b0_1_00000000, 6'd0}, 10};
        vecs[3] = '{1'b0, 28'h0000001, 8'h00, 8'hFF, {10'b0_1_11111111, 6'd0}, 10};
        vecs[4] = '{1'b1, 28'h8000000, 8'h81, 8'h5A, {2'b0_1, 14'd0}, 2};

        tick(3);
        check("reset_outputs", {ssi_miso, ssi_miso_oe, mem_req, mem_we, mem_addr, mem_wdata, busy}, 64'd0);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 5; i++) run_vector(i);

        // Reset mid-frame after 10 address bits, then a clean read.
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 27; i >= 18; i--) send_bit(vecs[0].addr[i]);
        tick(2);
        check("midframe_busy", 64'(busy), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {ssi_miso, ssi_miso_oe, mem_req, mem_we, mem_addr, mem_wdata, busy}, 64'd0);
        tick(2);
        rst = 1'b0;
        ssi_mosi = 1'b0;
        tick(4);
        run_vector(0);

        // Slow store: write frame, ack after 40 wait periods.
        mem_auto = 1'b0;
        send_frame(1'b1, 28'h0000123, 8'h77);
        resp_run(43, 40, 1, 8'h00);
        zeros  = 0;
        req_hi = 0;
        for (int k = 1; k <= 40; k++) if (miso_v[k] == 1'b0 && oe_v[k] == 1'b1) zeros++;
        for (int k = 0; k <= 40; k++) if (req_v[k]) req_hi++;
        check("slow_entry_bit", {62'd0, oe_v[0], miso_v[0]}, 64'd2);
        check("slow_wait_zeros", 64'(zeros), 64'd40);
        check("slow_req_held", 64'(req_hi), 64'd41);
        check("slow_ack_bit", {61'd0, oe_v[41], miso_v[41], req_v[41]}, 64'd6);
        check("slow_end", {61'd0, oe_v[42], miso_v[42], busy}, 64'd0);
        check("slow_mem_we", 64'(cap_we), 64'd1);

        // Ack coincident with a fall: ack bit appears one fall later.
        send_frame(1'b0, 28'h0123456, 8'h00);
        resp_run(13, 2, 2, 8'h96);
        begin
            logic [12:0] act13;
            for (int k = 0; k < 13; k++) act13[12-k] = miso_v[k];
            check("coinc_miso_stream", 64'(act13), 64'(13'b0_0_0_1_10010110_0));
        end
        check("coinc_oe_end", {62'd0, oe_v[11], oe_v[12]}, 64'd2);
        check("coinc_mem_addr", 64'(cap_addr), 64'h0123456);
        check("coinc_busy_end", 64'(busy), 64'd0);

        // Idle noise: 20 zero bits must not start a frame.
        mem_auto  = 1'b1;
        noise_bad = 0;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0);
            if (mem_req || busy) noise_bad++;
        end
        check("noise_no_activity", 64'(noise_bad), 64'd0);
        run_vector(1);
        run_vector(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
